// File: rtl/ir_action_ctrl.sv
// miniCar IR command decoder: maps validated remote frame codes onto action, speed,
// control mode and display page, with a dead-man hold timer and an emergency stop.
module ir_action_ctrl #(
  parameter int HOLD_CYCLES = 5_400_000,
  parameter int SPEED_W     = 3,
  parameter int SPEED_MAX   = 7,
  parameter int SPEED_INIT  = 3
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               frame_valid,
  input  logic [7:0]         frame_data,
  input  logic               repeat_valid,
  input  logic               estop,
  output logic [3:0]         action,
  output logic [SPEED_W-1:0] speed_level,
  output logic [1:0]         car_mode,
  output logic [2:0]         mode_seg_en,
  output logic               cmd_valid,
  output logic               timeout_flag
);

  localparam int                 CNT_W      = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST_C = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SPEED_W-1:0] SPD_MAX_C  = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] SPD_INIT_C = SPEED_W'(SPEED_INIT);
  localparam logic [3:0]         ACT_STOP_C = 4'hF;
  localparam logic [2:0]         SEG_INIT_C = 3'b010;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_TRACK  = 2'b10
  } mode_e;

  // Motion key table: {hit, action code}; hit=0 means the code is not a motion key.
  function automatic logic [4:0] motion_lookup(input logic [7:0] code);
    logic [4:0] res;
    case (code)
      8'h40:   res = {1'b1, 4'h3};
      8'h07:   res = {1'b1, 4'h4};
      8'h09:   res = {1'b1, 4'h5};
      8'h16:   res = {1'b1, 4'h6};
      8'h0D:   res = {1'b1, 4'h7};
      8'h43:   res = {1'b1, 4'h8};
      8'h44:   res = {1'b1, 4'h9};
      8'h19:   res = {1'b1, 4'hA};
      8'h15:   res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [3:0]         action_r;
  logic [SPEED_W-1:0] speed_r;
  mode_e              mode_r;
  logic [2:0]         seg_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               chg_r;
  logic               cmd_r;
  logic               to_r;

  logic [3:0]         action_nx_s;
  logic [SPEED_W-1:0] speed_nx_s;
  mode_e              mode_nx_s;
  logic [2:0]         seg_nx_s;
  logic [CNT_W-1:0]   cnt_nx_s;
  logic [4:0]         motion_s;
  logic               motion_ok_s;
  logic               refresh_s;
  logic               act_hit_s;
  logic               key_mode_s;
  mode_e              key_mode_tgt_s;
  logic               counting_s;
  logic               expire_s;
  logic               chg_s;

  // Next-state decode: key map, mode change, hold-timer expiry and estop override.
  always_comb begin
    action_nx_s    = action_r;
    speed_nx_s     = speed_r;
    mode_nx_s      = mode_r;
    seg_nx_s       = seg_r;
    cnt_nx_s       = cnt_r;
    motion_s       = motion_lookup(frame_data);
    motion_ok_s    = (mode_r == MODE_MANUAL) && !estop;
    refresh_s      = repeat_valid;
    act_hit_s      = 1'b0;
    key_mode_s     = 1'b0;
    key_mode_tgt_s = MODE_AUTO;
    counting_s     = (mode_r == MODE_MANUAL) && (action_r != ACT_STOP_C);
    expire_s       = 1'b0;

    if (frame_valid) begin
      case (frame_data)
        8'h45: begin
          mode_nx_s   = MODE_MANUAL;
          speed_nx_s  = SPD_INIT_C;
          seg_nx_s    = SEG_INIT_C;
          action_nx_s = ACT_STOP_C;
          act_hit_s   = 1'b1;
        end
        8'h47: begin
          action_nx_s = ACT_STOP_C;
          act_hit_s   = 1'b1;
        end
        8'h42: begin
          key_mode_s     = 1'b1;
          key_mode_tgt_s = MODE_MANUAL;
        end
        8'h52: begin
          key_mode_s     = 1'b1;
          key_mode_tgt_s = MODE_AUTO;
        end
        8'h4A: begin
          key_mode_s     = 1'b1;
          key_mode_tgt_s = MODE_TRACK;
        end
        8'h46:   speed_nx_s = (speed_r == SPD_MAX_C) ? speed_r : speed_r + SPEED_W'(1);
        8'h4B:   speed_nx_s = (speed_r == '0) ? speed_r : speed_r - SPEED_W'(1);
        8'h0C:   seg_nx_s = 3'b011;
        8'h18:   seg_nx_s = 3'b010;
        8'h5E:   seg_nx_s = 3'b001;
        8'h5A:   seg_nx_s = 3'b000;
        default: begin
          if (motion_s[4] && motion_ok_s) begin
            action_nx_s = motion_s[3:0];
            refresh_s   = 1'b1;
            act_hit_s   = 1'b1;
          end else begin
            act_hit_s = 1'b0;
          end
        end
      endcase
    end else begin
      key_mode_s = 1'b0;
    end

    // Re-selecting the current mode is a no-op; a real change always stops the car.
    if (key_mode_s && (key_mode_tgt_s != mode_r)) begin
      mode_nx_s   = key_mode_tgt_s;
      action_nx_s = ACT_STOP_C;
      act_hit_s   = 1'b1;
    end else begin
      mode_nx_s = mode_nx_s;
    end

    if (counting_s && (cnt_r == CNT_LAST_C) && !refresh_s && !act_hit_s && !estop) begin
      expire_s    = 1'b1;
      action_nx_s = ACT_STOP_C;
    end else begin
      expire_s = 1'b0;
    end

    if (estop) begin
      action_nx_s = ACT_STOP_C;
    end else begin
      action_nx_s = action_nx_s;
    end

    // The counter saturates at its last value instead of wrapping.
    if (refresh_s || (action_nx_s == ACT_STOP_C) || (mode_nx_s != mode_r)) begin
      cnt_nx_s = '0;
    end else if (counting_s && (cnt_r != CNT_LAST_C)) begin
      cnt_nx_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nx_s = cnt_r;
    end

    chg_s = (action_nx_s != action_r) || (speed_nx_s != speed_r) || (mode_nx_s != mode_r);
  end

  // State and output registers; cmd_valid trails the reported change by one cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      action_r <= ACT_STOP_C;
      speed_r  <= SPD_INIT_C;
      mode_r   <= MODE_AUTO;
      seg_r    <= SEG_INIT_C;
      cnt_r    <= '0;
      chg_r    <= 1'b0;
      cmd_r    <= 1'b0;
      to_r     <= 1'b0;
    end else begin
      action_r <= action_nx_s;
      speed_r  <= speed_nx_s;
      mode_r   <= mode_nx_s;
      seg_r    <= seg_nx_s;
      cnt_r    <= cnt_nx_s;
      chg_r    <= chg_s;
      cmd_r    <= chg_r;
      to_r     <= expire_s;
    end
  end

  assign action       = action_r;
  assign speed_level  = speed_r;
  assign car_mode     = mode_r;
  assign mode_seg_en  = seg_r;
  assign cmd_valid    = cmd_r;
  assign timeout_flag = to_r;

endmodule
